// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, oversample
// factor and the baud_select -> clock divisor mapping.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 32'd16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   function automatic int unsigned baud_rate(input logic [2:0] sel);
      int unsigned rate;
      case (sel)
         3'b000:  rate = 32'd300;
         3'b001:  rate = 32'd1200;
         3'b010:  rate = 32'd4800;
         3'b011:  rate = 32'd9600;
         3'b100:  rate = 32'd19200;
         3'b101:  rate = 32'd38400;
         3'b110:  rate = 32'd57600;
         default: rate = 32'd115200;
      endcase
      return rate;
   endfunction

   // Rounded clk_freq / (baud * oversample), never below 1 so the divider always ticks.
   function automatic logic [31:0] baud_divisor(input int unsigned clk_freq,
                                                input int unsigned oversample,
                                                input logic [2:0]  sel);
      int unsigned den;
      int unsigned div;
      den = baud_rate(sel) * oversample;
      div = (clk_freq + den / 32'd2) / den;
      if (div == 32'd0) begin
         div = 32'd1;
      end else begin
         div = div;
      end
      return div;
   endfunction

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Oversample tick generator: one-clock pulse every DIV clocks for the selected rate.
// The divisor table is resolved at elaboration, so no runtime divider is built.
module tx_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 32'd50_000_000,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       tick
);

   localparam logic [31:0] DIV_TAB [0:7] = '{
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd0),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd1),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd2),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd3),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd4),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd5),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd6),
      baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd7)
   };

   logic [31:0] div_s;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  sel_q, sel_d;
   logic        tick_q, tick_d;

   // Next divider count; a rate change restarts the count from zero.
   always_comb begin
      div_s  = DIV_TAB[baud_select];
      sel_d  = baud_select;
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (baud_select != sel_q) begin
         cnt_d  = 32'd0;
         tick_d = 1'b0;
      end else if (cnt_q >= div_s - 32'd1) begin
         cnt_d  = 32'd0;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + 32'd1;
         tick_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q  <= 32'd0;
         sel_q  <= baud_select;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/transmitter_uart.sv
// UART transmitter: start bit, 8 data bits LSB first, even parity, stop bit,
// with a one-byte holding register so the next byte can queue during a frame.
module transmitter_uart
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 32'd50_000_000,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   output logic       TxD,
   output logic       Tx_READY,
   output logic       Tx_BUSY,
   output logic       Tx_DONE,
   output logic       Tx_OVERRUN
);

   localparam int          TW        = (OVERSAMPLE > 32'd1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 32'd1);

   logic            tick_s;
   logic            bit_end_s;
   logic            load_s;
   logic            accept_s;

   tx_state_e       state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            parity_q, parity_d;
   logic [7:0]      hold_q, hold_d;
   logic            ready_q, ready_d;
   logic            txd_q, txd_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;

   tx_baud_gen #(
      .CLK_FREQ   (CLK_FREQ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud_gen (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .tick        (tick_s)
   );

   // Frame sequencing, holding-register handshake and registered line outputs.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      hold_d     = hold_q;
      ready_d    = ready_q;
      txd_d      = txd_q;
      done_d     = 1'b0;
      load_s     = 1'b0;
      bit_end_s  = tick_s && (tick_cnt_q == TICK_LAST);

      if (tick_s && (state_q != ST_IDLE)) begin
         tick_cnt_d = bit_end_s ? '0 : tick_cnt_q + 1'b1;
      end else begin
         tick_cnt_d = tick_cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            load_s = tick_s && Tx_EN && !ready_q;
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
               txd_d     = shift_q[0];
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s && (bit_idx_q == 3'd7)) begin
               state_d = ST_PARITY;
               txd_d   = parity_q;
            end else if (bit_end_s) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               txd_d     = shift_q[1];
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               done_d = 1'b1;
               load_s = Tx_EN && !ready_q;
               state_d = ST_IDLE;
               txd_d   = 1'b1;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // Moving the held byte into the shifter both starts a frame and frees the holding slot.
      if (load_s) begin
         shift_d    = hold_q;
         parity_d   = even_parity(hold_q);
         state_d    = ST_START;
         txd_d      = 1'b0;
         tick_cnt_d = '0;
         bit_idx_d  = 3'd0;
      end else begin
         shift_d = shift_d;
      end

      accept_s  = Tx_WR && (ready_q || load_s);
      overrun_d = Tx_WR && !accept_s;
      if (accept_s) begin
         hold_d  = Tx_DATA;
         ready_d = 1'b0;
      end else if (load_s) begin
         ready_d = 1'b1;
      end else begin
         ready_d = ready_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         parity_q   <= 1'b0;
         hold_q     <= 8'h00;
         ready_q    <= 1'b1;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         hold_q     <= hold_d;
         ready_q    <= ready_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overrun_q  <= overrun_d;
      end
   end

   assign TxD        = txd_q;
   assign Tx_READY   = ready_q;
   assign Tx_BUSY    = busy_q;
   assign Tx_DONE    = done_q;
   assign Tx_OVERRUN = overrun_q;

endmodule

// File: tb/tb_transmitter_uart.sv
// Directed bench for transmitter_uart: frame content, bit timing, back-to-back
// frames, overrun, enable gating, mid-frame reset and a serial decode at another rate.
module tb_transmitter_uart;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] baud_select;
   logic       Tx_EN;
   logic       Tx_WR;
   logic [7:0] Tx_DATA;
   logic       TxD;
   logic       Tx_READY;
   logic       Tx_BUSY;
   logic       Tx_DONE;
   logic       Tx_OVERRUN;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int edges[$];
   logic prev_txd = 1'b1;

   transmitter_uart dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Tx_EN       (Tx_EN),
      .Tx_WR       (Tx_WR),
      .Tx_DATA     (Tx_DATA),
      .TxD         (TxD),
      .Tx_READY    (Tx_READY),
      .Tx_BUSY     (Tx_BUSY),
      .Tx_DONE     (Tx_DONE),
      .Tx_OVERRUN  (Tx_OVERRUN)
   );

   always #5 clk = ~clk;

   // Cycle counter: number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   // Records the cycle of every TxD transition.
   always @(negedge clk) begin
      if (TxD !== prev_txd) edges.push_back(cyc);
      prev_txd <= TxD;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_byte(input logic [7:0] d);
      Tx_DATA = d;
      Tx_WR   = 1'b1;
      @(negedge clk);
      Tx_WR   = 1'b0;
      Tx_DATA = 8'h00;
   endtask

   task automatic wait_txd(input logic val, input int max_cyc, output int t);
      int n;
      n = 0;
      while (TxD !== val && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      t = (TxD === val) ? cyc : -1;
   endtask

   task automatic wait_ready(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (Tx_READY !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(Tx_READY), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int max_cyc, output int t);
      int n;
      n = 0;
      while (Tx_DONE !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(Tx_DONE), 32'd1);
      t = cyc;
   endtask

   // Finds the start bit, then samples the middle of all 11 bit periods.
   task automatic capture(input string tag, input int bit_clk, input int max_wait,
                          output logic [10:0] bits, output int t0);
      wait_txd(1'b0, max_wait, t0);
      chk({tag, "_start"}, 32'(TxD), 32'd0);
      bits = '1;
      if (t0 >= 0) begin
         repeat (bit_clk / 2) @(negedge clk);
         bits[0] = TxD;
         for (int k = 1; k < 11; k++) begin
            repeat (bit_clk) @(negedge clk);
            bits[k] = TxD;
         end
      end
   endtask

   logic [10:0] fr;
   int t0, t1, td, n_low;

   initial begin
      reset       = 1'b0;
      baud_select = 3'b111;
      Tx_EN       = 1'b0;
      Tx_WR       = 1'b0;
      Tx_DATA     = 8'h00;
      repeat (5) @(negedge clk);
      chk("rst_txd",     32'(TxD),        32'd1);
      chk("rst_ready",   32'(Tx_READY),   32'd1);
      chk("rst_busy",    32'(Tx_BUSY),    32'd0);
      chk("rst_done",    32'(Tx_DONE),    32'd0);
      chk("rst_overrun", 32'(Tx_OVERRUN), 32'd0);
      reset = 1'b1;
      Tx_EN = 1'b1;
      repeat (3) @(negedge clk);

      // 1: single frame 0x55 at 115200 (27 clk/tick, 432 clk/bit)
      edges.delete();
      write_byte(8'h55);
      chk("t1_ready_low", 32'(Tx_READY), 32'd0);
      capture("t1", 432, 100, fr, t0);
      chk("t1_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h55, 1'b0}));
      wait_done("t1_done_seen", 600, td);
      chk("t1_done_time", 32'(td - edges[0]), 32'd4752);
      chk("t1_edge_count", 32'(edges.size()), 32'd10);
      if (edges.size() >= 10) begin
         chk("t1_bit0_width", 32'(edges[1] - edges[0]), 32'd432);
         chk("t1_eight_bits", 32'(edges[8] - edges[0]), 32'd3456);
         chk("t1_stop_edge",  32'(edges[9] - edges[0]), 32'd4320);
      end
      @(negedge clk);
      chk("t1_done_pulse", 32'(Tx_DONE), 32'd0);
      chk("t1_idle_busy",  32'(Tx_BUSY), 32'd0);
      repeat (40) @(negedge clk);

      // 2: back-to-back 0x07 (parity 1) then 0xA3 (parity 0)
      edges.delete();
      write_byte(8'h07);
      chk("t2_ready_low1", 32'(Tx_READY), 32'd0);
      wait_ready("t2_ready_back", 60);
      chk("t2_busy", 32'(Tx_BUSY), 32'd1);
      write_byte(8'hA3);
      chk("t2_ready_low2", 32'(Tx_READY), 32'd0);
      capture("t2a", 432, 100, fr, t0);
      chk("t2a_frame", 32'(fr), 32'({1'b1, 1'b1, 8'h07, 1'b0}));
      capture("t2b", 432, 400, fr, t1);
      chk("t2b_frame", 32'(fr), 32'({1'b1, 1'b0, 8'hA3, 1'b0}));
      chk("t2_no_gap", 32'(t1 - edges[0]), 32'd4752);
      chk("t2_ready_after", 32'(Tx_READY), 32'd1);
      wait_done("t2_done_seen", 600, td);
      repeat (40) @(negedge clk);

      // 3: overrun while holding is full; the dropped byte must never be sent
      write_byte(8'h11);
      wait_ready("t3_ready_back", 60);
      write_byte(8'h22);
      write_byte(8'h33);
      chk("t3_overrun_pulse", 32'(Tx_OVERRUN), 32'd1);
      @(negedge clk);
      chk("t3_overrun_clear", 32'(Tx_OVERRUN), 32'd0);
      capture("t3a", 432, 100, fr, t0);
      chk("t3a_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h11, 1'b0}));
      capture("t3b", 432, 400, fr, t0);
      chk("t3b_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h22, 1'b0}));
      wait_done("t3_done_seen", 600, td);
      n_low = 0;
      repeat (600) begin
         @(negedge clk);
         if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) n_low++;
      end
      chk("t3_no_third_frame", 32'(n_low), 32'd0);

      // 4: Tx_EN low holds the byte; raising it starts on the next tick
      Tx_EN = 1'b0;
      write_byte(8'h5A);
      repeat (200) @(negedge clk);
      chk("t4_txd_idle", 32'(TxD),      32'd1);
      chk("t4_busy_idle", 32'(Tx_BUSY), 32'd0);
      chk("t4_held",     32'(Tx_READY), 32'd0);
      Tx_EN = 1'b1;
      capture("t4", 432, 28, fr, t0);
      chk("t4_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h5A, 1'b0}));
      wait_done("t4_done_seen", 600, td);
      repeat (40) @(negedge clk);

      // 5: reset during data bit 4, then a clean frame
      write_byte(8'h0F);
      wait_txd(1'b0, 100, t0);
      chk("t5_start", 32'(TxD), 32'd0);
      repeat (216 + 5 * 432) @(negedge clk);
      chk("t5_busy_mid", 32'(Tx_BUSY), 32'd1);
      chk("t5_txd_mid",  32'(TxD),     32'd0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("t5_rst_txd",   32'(TxD),      32'd1);
      chk("t5_rst_ready", 32'(Tx_READY), 32'd1);
      chk("t5_rst_busy",  32'(Tx_BUSY),  32'd0);
      repeat (3) @(negedge clk);
      write_byte(8'hC3);
      capture("t5", 432, 100, fr, t0);
      chk("t5_frame", 32'(fr), 32'({1'b1, 1'b0, 8'hC3, 1'b0}));
      wait_done("t5_done_seen", 600, td);
      repeat (40) @(negedge clk);

      // 6a: 9600 baud bit width (326 clk/tick -> 5216 clk/bit), then abort
      baud_select = 3'b011;
      @(negedge clk);
      write_byte(8'h01);
      wait_txd(1'b0, 400, t0);
      chk("t6_start", 32'(TxD), 32'd0);
      wait_txd(1'b1, 6000, t1);
      chk("t6_bit_width", 32'(t1 - t0), 32'd5216);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("t6_abort_busy", 32'(Tx_BUSY), 32'd0);

      // 6b: serial decode at 57600 (54 clk/tick -> 864 clk/bit)
      baud_select = 3'b110;
      repeat (3) @(negedge clk);
      write_byte(8'h00);
      capture("t6_00", 864, 120, fr, t0);
      chk("t6_00_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
      write_byte(8'hFF);
      capture("t6_ff", 864, 1000, fr, t0);
      chk("t6_ff_frame", 32'(fr), 32'({1'b1, 1'b0, 8'hFF, 1'b0}));
      write_byte(8'h3C);
      capture("t6_3c", 864, 1000, fr, t0);
      chk("t6_3c_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h3C, 1'b0}));
      wait_done("t6_done_seen", 1000, td);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
